// File: rtl/ternary_mvm_engine_if.sv
// Stream bundle for ternary_mvm_engine: 16-bit command/data input, ACC_W-bit result output.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Ports: in_data/in_valid/in_ready (command words), out_data/out_valid/out_ready (results), busy.
interface ternary_mvm_engine_if #(
  parameter int ACC_W = 16
);
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/ternary_mvm_engine.sv
// Ternary matrix-vector engine: loads W[in_len][out_len] in {-1,0,+1}, computes y = W^T x over int8 x.
// Latency: first result 1 cycle after the last multiply word; one accumulate per input word.
// Backpressure: in_valid low stalls LOAD/MULT indefinitely; in_ready is 0 while results are streamed,
//   and out_data is held while out_valid && !out_ready.
// Ports: clk, rst_n (async active-low), bus (slave side of ternary_mvm_engine_if).
module ternary_mvm_engine #(
  parameter int         MAX_IN_LEN  = 16,
  parameter int         MAX_OUT_LEN = 8,
  parameter int         ACC_W       = 16,
  parameter logic [3:0] OP_LOAD     = 4'hA,
  parameter logic [3:0] OP_MULT     = 4'hB
) (
  input  logic                clk,
  input  logic                rst_n,
  ternary_mvm_engine_if.slave bus
);

  localparam int LW = $clog2(MAX_IN_LEN + 1);   // holds 0..MAX_IN_LEN
  localparam int OW = $clog2(MAX_OUT_LEN + 1);  // holds 0..MAX_OUT_LEN
  localparam int IW = $clog2(MAX_IN_LEN);
  localparam int JW = (MAX_OUT_LEN > 1) ? $clog2(MAX_OUT_LEN) : 1;
  localparam int NI = 1 << IW;
  localparam int NJ = 1 << JW;

  typedef enum logic [1:0] {IDLE, LOAD, MULT, OUT} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    in_len_q;
  logic [OW-1:0]    out_len_q;
  logic [LW-1:0]    ld_i_q, ld_i_d, ci;
  logic [OW-1:0]    ld_j_q, ld_j_d, cj;
  logic [LW-1:0]    mul_i_q;
  logic [OW-1:0]    idx_q;
  logic [1:0]       w_q   [NI][NJ];
  logic [ACC_W-1:0] acc_q [NJ];
  logic [ACC_W-1:0] acc_d [NJ];

  logic             xfer_in, xfer_out, ld_last, mul_last;
  logic [7:0]       wr_en;
  logic [IW-1:0]    wr_i [8];
  logic [JW-1:0]    wr_j [8];
  logic [IW-1:0]    row0, row1;
  logic [7:0]       x0, x1;
  logic [6:0]       hdr_in_raw, hdr_out_raw;
  logic [LW-1:0]    hdr_in_len;
  logic [OW-1:0]    hdr_out_len;
  logic [3:0]       opcode;

  // Ternary product, sign-extended; arithmetic wraps modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] tern(input logic [1:0] w, input logic [7:0] x);
    logic [ACC_W-1:0] xe;
    xe = {{(ACC_W-8){x[7]}}, x};
    case (w)
      2'b01:   tern = xe;
      2'b11:   tern = -xe;
      default: tern = '0;
    endcase
  endfunction

  assign opcode   = bus.in_data[15:12];
  assign xfer_in  = bus.in_valid && bus.in_ready;
  assign xfer_out = bus.out_valid && bus.out_ready;

  // Header dimensions are stored minus one; clamp oversize requests to the build maximum.
  assign hdr_in_raw  = {1'b0, bus.in_data[11:6]} + 7'd1;
  assign hdr_out_raw = {1'b0, bus.in_data[5:0]} + 7'd1;
  assign hdr_in_len  = (hdr_in_raw  > 7'(MAX_IN_LEN))  ? LW'(MAX_IN_LEN)  : LW'(hdr_in_raw);
  assign hdr_out_len = (hdr_out_raw > 7'(MAX_OUT_LEN)) ? OW'(MAX_OUT_LEN) : OW'(hdr_out_raw);

  // Walk the row-major (i, j) cursor across the 8 weight fields of this word instead of
  // dividing the flat index by out_len. Once the cursor reaches row in_len the rest of the
  // word is padding, and that word is the last of the load.
  always_comb begin
    ci = ld_i_q;
    cj = ld_j_q;
    for (int m = 0; m < 8; m++) begin
      wr_en[m] = 1'b0;
      wr_i[m]  = ci[IW-1:0];
      wr_j[m]  = cj[JW-1:0];
      if (ci < in_len_q) begin
        wr_en[m] = 1'b1;
        if (cj == out_len_q - OW'(1)) begin
          cj = '0;
          ci = ci + LW'(1);
        end else begin
          cj = cj + OW'(1);
        end
      end
    end
    ld_i_d  = ci;
    ld_j_d  = cj;
    ld_last = (ci == in_len_q);
  end

  // Two rows per word; row0 is always even so row1 is row0 with bit 0 set.
  // An odd in_len leaves the upper byte of the final word unused.
  always_comb begin
    row0     = mul_i_q[IW-1:0];
    row1     = row0 | IW'(1);
    x0       = bus.in_data[7:0];
    x1       = (mul_i_q + LW'(1) < in_len_q) ? bus.in_data[15:8] : 8'd0;
    mul_last = (mul_i_q + LW'(2) >= in_len_q);
    for (int j = 0; j < NJ; j++) begin
      acc_d[j] = acc_q[j] + tern(w_q[row0][j], x0) + tern(w_q[row1][j], x1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b1;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.busy      = 1'b1;
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (xfer_in && opcode == OP_LOAD)      state_d = LOAD;
        else if (xfer_in && opcode == OP_MULT) state_d = MULT;
      end
      LOAD: if (xfer_in && ld_last)  state_d = IDLE;
      MULT: if (xfer_in && mul_last) state_d = OUT;
      OUT: begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b1;
        bus.out_data  = acc_q[idx_q[JW-1:0]];
        if (xfer_out && idx_q == out_len_q - OW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_len_q  <= LW'(MAX_IN_LEN);
      out_len_q <= OW'(MAX_OUT_LEN);
      ld_i_q    <= '0;
      ld_j_q    <= '0;
      mul_i_q   <= '0;
      idx_q     <= '0;
      for (int i = 0; i < NI; i++)
        for (int j = 0; j < NJ; j++)
          w_q[i][j] <= 2'b00;
      for (int j = 0; j < NJ; j++) acc_q[j] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer_in && opcode == OP_LOAD) begin
            in_len_q  <= hdr_in_len;
            out_len_q <= hdr_out_len;
            ld_i_q    <= '0;
            ld_j_q    <= '0;
          end else if (xfer_in && opcode == OP_MULT) begin
            mul_i_q <= '0;
            idx_q   <= '0;
            for (int j = 0; j < NJ; j++) acc_q[j] <= '0;
          end
        end
        LOAD: begin
          if (xfer_in) begin
            ld_i_q <= ld_i_d;
            ld_j_q <= ld_j_d;
            for (int m = 0; m < 8; m++)
              if (wr_en[m]) w_q[wr_i[m]][wr_j[m]] <= bus.in_data[2*m +: 2];
          end
        end
        MULT: begin
          if (xfer_in) begin
            mul_i_q <= mul_i_q + LW'(2);
            for (int j = 0; j < NJ; j++) acc_q[j] <= acc_d[j];
          end
        end
        OUT: if (xfer_out) idx_q <= idx_q + OW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_mvm_engine.sv
// Directed scoreboard bench for ternary_mvm_engine: a 16x8/ACC_W=16 instance and a 64x2/ACC_W=14 instance.
module tb_ternary_mvm_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ternary_mvm_engine_if #(.ACC_W(16)) if1();
  ternary_mvm_engine_if #(.ACC_W(14)) if2();

  ternary_mvm_engine #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  ternary_mvm_engine #(.MAX_IN_LEN(64), .MAX_OUT_LEN(2), .ACC_W(14)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp1[$];
  logic [15:0] exp2[$];
  bit          bp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor for the 16x8 instance, also producing out_ready back-pressure when bp is set.
  int          stall1 = 0;
  bit          held1 = 1'b0;
  logic [15:0] held_dat1;
  always @(negedge clk) begin
    if (!rst_n) begin
      if1.out_ready = 1'b1;
      held1 = 1'b0;
      stall1 = 0;
    end else begin
      if (bp && if1.out_valid && stall1 < 3) begin
        if1.out_ready = 1'b0;
        stall1++;
      end else begin
        if1.out_ready = 1'b1;
      end
      if (if1.out_valid) begin
        check("in_ready_during_out", 32'(if1.in_ready), 32'd0);
        if (held1) check("out_data_held", 32'(if1.out_data), 32'(held_dat1));
        if (if1.out_ready) begin
          if (exp1.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got 0x%0h, expected no output", if1.out_data);
          end else begin
            check("out_data", 32'(if1.out_data), 32'(exp1.pop_front()));
          end
          held1 = 1'b0;
          stall1 = 0;
        end else begin
          held1 = 1'b1;
          held_dat1 = if1.out_data;
        end
      end
    end
  end

  // Monitor for the 64x2 / 14-bit instance (always ready).
  always @(negedge clk) begin
    if2.out_ready = 1'b1;
    if (rst_n && if2.out_valid) begin
      check("in_ready_during_out2", 32'(if2.in_ready), 32'd0);
      if (exp2.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out2: got 0x%0h, expected no output", if2.out_data);
      end else begin
        check("out_data2", 32'(if2.out_data), 32'(exp2.pop_front()));
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following the transfer.
  task automatic send(input bit sel, input logic [15:0] d);
    int t = 0;
    if (sel) begin if2.in_data = d; if2.in_valid = 1'b1; end
    else     begin if1.in_data = d; if1.in_valid = 1'b1; end
    while (!(sel ? if2.in_ready : if1.in_ready)) begin
      @(negedge clk);
      t++;
      if (t > 1000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 1000 cycles");
        break;
      end
    end
    @(negedge clk);
    if (sel) if2.in_valid = 1'b0;
    else     if1.in_valid = 1'b0;
  endtask

  task automatic send_n(input bit sel, input logic [15:0] d, input int n);
    for (int k = 0; k < n; k++) send(sel, d);
  endtask

  task automatic push_n(input bit sel, input logic [15:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      if (sel) exp2.push_back(v);
      else     exp1.push_back(v);
    end
  endtask

  task automatic wait_done(input bit sel, input string name);
    int t = 0;
    while (((sel ? exp2.size() : exp1.size()) != 0 || (sel ? if2.busy : if1.busy) !== 1'b0)
           && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_busy_end"}, 32'(sel ? if2.busy : if1.busy), 32'd0);
    check({name, "_all_outputs_seen"}, 32'(sel ? exp2.size() : exp1.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"},  32'(if1.in_ready),  32'd1);
    check({name, "_out_valid"}, 32'(if1.out_valid), 32'd0);
    check({name, "_out_data"},  32'(if1.out_data),  32'd0);
    check({name, "_busy"},      32'(if1.busy),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0;
    if2.in_valid = 1'b0; if2.in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_busy2", 32'(if2.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unknown opcode in IDLE is swallowed.
    send(0, 16'h1234);
    check("junk_busy", 32'(if1.busy), 32'd0);
    @(negedge clk);
    check("junk_busy_later", 32'(if1.busy), 32'd0);

    // MULT straight after reset: zero weights, MAX dims -> 8 zeros from 8 words.
    push_n(0, 16'h0000, 8);
    send(0, 16'hB000);
    send_n(0, 16'h7F7F, 8);
    wait_done(0, "mult_no_load");

    // Basic 2x2: W00=+1 W01=-1 W10=0 W11=+1, x=(5,-3) -> 5, -8.
    send(0, 16'hA041);
    send(0, 16'h004D);
    push_n(0, 16'h0005, 1);
    push_n(0, 16'hFFF8, 1);
    send(0, 16'hB000);
    send(0, 16'hFD05);
    wait_done(0, "basic_2x2");

    // Same again with out_ready held low 3 cycles per result.
    bp = 1'b1;
    send(0, 16'hA041);
    send(0, 16'h004D);
    push_n(0, 16'h0005, 1);
    push_n(0, 16'hFFF8, 1);
    send(0, 16'hB000);
    send(0, 16'hFD05);
    wait_done(0, "backpressure");
    bp = 1'b0;

    // in_len=3, out_len=1, all +1; x = 127,127,127 (+ ignored 0x80) with gaps -> 381.
    send(0, 16'hA080);
    @(negedge clk);
    send(0, 16'h0015);
    @(negedge clk);
    push_n(0, 16'h017D, 1);
    send(0, 16'hB000);
    @(negedge clk);
    send(0, 16'h7F7F);
    @(negedge clk);
    send(0, 16'h807F);
    wait_done(0, "odd_len");

    // Oversize header clamps to 16x8; all -1, x=-128 -> 2048 each.
    send(0, 16'hAFFF);
    send_n(0, 16'hFFFF, 16);
    push_n(0, 16'h0800, 8);
    send(0, 16'hB000);
    send_n(0, 16'h8080, 8);
    wait_done(0, "full_size");

    // MULT header dimension fields are ignored: still 16x8.
    push_n(0, 16'h0800, 8);
    send(0, 16'hB041);
    send_n(0, 16'h8080, 8);
    wait_done(0, "mult_dims_ignored");

    // Async reset part-way through a load, then MULT sees cleared weights.
    send(0, 16'hAFFF);
    send_n(0, 16'h5555, 3);
    check("mid_load_busy", 32'(if1.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_n(0, 16'h0000, 8);
    send(0, 16'hB000);
    send_n(0, 16'h0101, 8);
    wait_done(0, "after_reset");

    // 64x2, ACC_W=14: column 0 weights +1, column 1 weights -1.
    send(1, 16'hAFC1);
    send_n(1, 16'hDDDD, 16);
    push_n(1, 16'h2000, 1);   // -8192
    push_n(1, 16'h2000, 1);   // +8192 wraps to -8192
    send(1, 16'hB000);
    send_n(1, 16'h8080, 32);
    wait_done(1, "wrap14_neg");
    push_n(1, 16'h1FC0, 1);   // +8128
    push_n(1, 16'h2040, 1);   // -8128
    send(1, 16'hB000);
    send_n(1, 16'h7F7F, 32);
    wait_done(1, "wrap14_pos");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
